// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / flag-dependence stall, taken-branch flush and
// slow-memory freeze control for the five-stage pipeline, with a memory-wait
// watchdog and saturating stall/flush statistics.

module pipe_hazard_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rn,
   input  logic [4:0]       id_r2,
   input  logic             id_uses_rn,
   input  logic             id_uses_r2,
   input  logic             id_condbr,
   input  logic             id_br_taken,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_regwrite,
   input  logic             ex_flagwrite,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_bubble,
   output logic             ex_mem_en,
   output logic             mem_wb_bubble,
   output logic             state,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   // Watchdog counter is at least 8 bits, wider only if TIMEOUT needs it.
   localparam int WAIT_W = (TIMEOUT >= 256) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            cur_state;
   state_t            next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_next;

   logic freeze;
   logic load_use;
   logic flag_stall;
   logic stall;
   logic flush;

   // Hazard terms; X31 reads as zero so it can never create a dependence.
   always_comb begin
      freeze     = mem_req & ~mem_ready;
      load_use   = ex_memread & ex_regwrite & (ex_rd != 5'd31) &
                   ((id_uses_rn & (id_rn == ex_rd)) |
                    (id_uses_r2 & (id_r2 == ex_rd)));
      flag_stall = id_condbr & ex_flagwrite;
      stall      = ~freeze & (load_use | flag_stall);
      flush      = ~freeze & ~stall & id_br_taken;
   end

   // Pipeline control: reset forces everything to NOP, then freeze > stall > flush.
   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_en      = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_en     = 1'b1;
      mem_wb_bubble = 1'b0;
      if (reset) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_en      = 1'b0;
         id_ex_bubble  = 1'b1;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (freeze) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_en      = 1'b0;
         ex_mem_en     = 1'b0;
         mem_wb_bubble = 1'b1;
      end else if (stall) begin
         pc_en         = 1'b0;
         if_id_en      = 1'b0;
         id_ex_bubble  = 1'b1;
      end else if (flush) begin
         if_id_flush   = 1'b1;
      end
   end

   // Next state and next watchdog count; the freeze itself never depends on state.
   always_comb begin
      next_state    = cur_state;
      wait_cnt_next = '0;
      case (cur_state)
         RUN: begin
            if (freeze) begin
               next_state = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            wait_cnt_next = (wait_cnt == TIMEOUT_V) ? wait_cnt : wait_cnt + WAIT_ONE;
            if (mem_ready || !mem_req) begin
               next_state = RUN;
            end
         end
         default: begin
            next_state = RUN;
         end
      endcase
   end

   // State register, watchdog counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state   <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         cur_state <= next_state;
         wait_cnt  <= wait_cnt_next;
         if (wait_cnt_next == TIMEOUT_V) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   // Saturating statistics: lost fetch cycles and issued fetch flushes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if ((freeze || stall) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_ONE;
         end
         if (flush && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_ONE;
         end
      end
   end

   assign state = (cur_state == MEM_WAIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized stimulus, expected outputs
// queued by a behavioural model and compared by an independent monitor.

module tb_pipe_hazard_ctrl;

   localparam int CNT_W   = 5;
   localparam int TIMEOUT = 4;
   localparam int MAXC    = (1 << CNT_W) - 1;

   typedef struct packed {
      logic       rst;
      logic [4:0] id_rn;
      logic [4:0] id_r2;
      logic       id_uses_rn;
      logic       id_uses_r2;
      logic       id_condbr;
      logic       id_br_taken;
      logic [4:0] ex_rd;
      logic       ex_memread;
      logic       ex_regwrite;
      logic       ex_flagwrite;
      logic       mem_req;
      logic       mem_ready;
   } in_t;

   typedef struct packed {
      logic             pc_en;
      logic             if_id_en;
      logic             if_id_flush;
      logic             id_ex_en;
      logic             id_ex_bubble;
      logic             ex_mem_en;
      logic             mem_wb_bubble;
      logic             state;
      logic             mem_timeout;
      logic [CNT_W-1:0] stall_cycles;
      logic [CNT_W-1:0] flush_count;
   } out_t;

   logic             clk = 1'b0;
   logic             reset;
   logic [4:0]       id_rn, id_r2, ex_rd;
   logic             id_uses_rn, id_uses_r2, id_condbr, id_br_taken;
   logic             ex_memread, ex_regwrite, ex_flagwrite, mem_req, mem_ready;
   logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
   logic             ex_mem_en, mem_wb_bubble, state, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   out_t expQ[$];
   int   applied     = 0;
   int   miscompares = 0;
   bit   driveDone   = 1'b0;

   // Reference model state: in a memory wait or not, length of the current
   // wait, sticky timeout and the two statistics as plain integers.
   bit   mWait;
   int   mLen;
   bit   mTimeout;
   int   mStall;
   int   mFlush;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_r2(id_r2), .id_uses_rn(id_uses_rn), .id_uses_r2(id_uses_r2),
      .id_condbr(id_condbr), .id_br_taken(id_br_taken),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
      .ex_flagwrite(ex_flagwrite), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
      .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
      .mem_wb_bubble(mem_wb_bubble), .state(state), .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   // 10-unit clock; inputs change 1 unit after each rising edge.
   always #5 clk = ~clk;

   // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
   task automatic applyStimulus(input in_t s);
      out_t e;
      bit   fr, lu, fs, st, fl;
      @(posedge clk);
      #1;
      reset        = s.rst;
      id_rn        = s.id_rn;
      id_r2        = s.id_r2;
      id_uses_rn   = s.id_uses_rn;
      id_uses_r2   = s.id_uses_r2;
      id_condbr    = s.id_condbr;
      id_br_taken  = s.id_br_taken;
      ex_rd        = s.ex_rd;
      ex_memread   = s.ex_memread;
      ex_regwrite  = s.ex_regwrite;
      ex_flagwrite = s.ex_flagwrite;
      mem_req      = s.mem_req;
      mem_ready    = s.mem_ready;

      if (s.rst) begin
         mWait = 0; mLen = 0; mTimeout = 0; mStall = 0; mFlush = 0;
      end

      fr = s.mem_req && !s.mem_ready;
      lu = s.ex_memread && s.ex_regwrite && (int'(s.ex_rd) != 31) &&
           ((s.id_uses_rn && s.id_rn == s.ex_rd) || (s.id_uses_r2 && s.id_r2 == s.ex_rd));
      fs = s.id_condbr && s.ex_flagwrite;
      st = !fr && (lu || fs);
      fl = !fr && !st && s.id_br_taken;

      e = '0;
      if (s.rst) begin
         e.if_id_flush = 1; e.id_ex_bubble = 1; e.mem_wb_bubble = 1;
      end else if (fr) begin
         e.mem_wb_bubble = 1;
      end else if (st) begin
         e.id_ex_en = 1; e.id_ex_bubble = 1; e.ex_mem_en = 1;
      end else begin
         e.pc_en = 1; e.if_id_en = 1; e.id_ex_en = 1; e.ex_mem_en = 1;
         e.if_id_flush = fl;
      end
      e.state        = mWait;
      e.mem_timeout  = mTimeout;
      e.stall_cycles = CNT_W'(mStall);
      e.flush_count  = CNT_W'(mFlush);
      expQ.push_back(e);
      applied++;

      if (!s.rst) begin
         if (mWait) begin
            mLen++;
            if (mLen >= TIMEOUT) mTimeout = 1;
         end else begin
            mLen = 0;
         end
         mWait = fr;
         if ((fr || st) && mStall < MAXC) mStall++;
         if (fl && mFlush < MAXC) mFlush++;
      end
   endtask

   // Compare the DUT's present outputs against one queued expectation.
   task automatic checkOutput(input out_t e);
      out_t a;
      a = '{pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en,
            mem_wb_bubble, state, mem_timeout, stall_cycles, flush_count};
      if (a !== e) begin
         miscompares++;
         $display("[TB] FAIL outputs t=%0t got=%b/%0d/%0d expected=%b/%0d/%0d",
                  $time, a[2*CNT_W+8:2*CNT_W], a.stall_cycles, a.flush_count,
                  e[2*CNT_W+8:2*CNT_W], e.stall_cycles, e.flush_count);
      end
   endtask

   // Monitor: every falling edge, pop the pending expectation and check it.
   initial begin
      out_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Stimulus: directed scenarios first, then a randomized stream.
   initial begin
      in_t s;
      in_t idle;
      idle = '0;
      reset = 1'b1;
      {id_rn, id_r2, ex_rd} = '0;
      {id_uses_rn, id_uses_r2, id_condbr, id_br_taken} = '0;
      {ex_memread, ex_regwrite, ex_flagwrite, mem_req, mem_ready} = '0;

      s = idle; s.rst = 1;
      applyStimulus(s);
      applyStimulus(s);
      applyStimulus(idle);

      // load-use on Rn, then the same through X31
      s = idle; s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 5;
      s.id_rn = 5; s.id_uses_rn = 1;
      applyStimulus(s);
      applyStimulus(idle);
      s.ex_rd = 31; s.id_rn = 31;
      applyStimulus(s);

      // taken branch alone, then with load-use on the second port
      s = idle; s.id_br_taken = 1;
      applyStimulus(s);
      s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 9; s.id_r2 = 9; s.id_uses_r2 = 1;
      applyStimulus(s);
      s.ex_regwrite = 0;
      applyStimulus(s);

      // flag dependence with and without a flag-writing execute instruction
      s = idle; s.id_condbr = 1; s.ex_flagwrite = 1;
      applyStimulus(s);
      s.ex_flagwrite = 0;
      applyStimulus(s);

      // slow memory: three waits then ready
      s = idle; s.mem_req = 1;
      repeat (3) applyStimulus(s);
      s.mem_ready = 1;
      applyStimulus(s);
      applyStimulus(idle);

      // freeze and load-use together: freeze wins, load-use returns after
      s = idle; s.mem_req = 1; s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 3;
      s.id_rn = 3; s.id_uses_rn = 1;
      applyStimulus(s);
      s.mem_ready = 1;
      applyStimulus(s);
      applyStimulus(idle);

      // watchdog: six waits, release, then stays set
      s = idle; s.mem_req = 1;
      repeat (6) applyStimulus(s);
      s.mem_ready = 1;
      applyStimulus(s);
      applyStimulus(idle);

      // reset in the middle of a wait, seen before the next rising edge
      s = idle; s.mem_req = 1;
      repeat (5) applyStimulus(s);
      s.rst = 1;
      applyStimulus(s);
      s = idle;
      applyStimulus(s);

      // randomized stream with register fields drawn from a small pool
      for (int i = 0; i < 700; i++) begin
         s = '0;
         s.rst          = ($urandom_range(0, 199) == 0);
         s.id_rn        = 5'($urandom_range(29, 31));
         s.id_r2        = 5'($urandom_range(29, 31));
         s.ex_rd        = 5'($urandom_range(29, 31));
         s.id_uses_rn   = 1'($urandom);
         s.id_uses_r2   = 1'($urandom);
         s.id_condbr    = ($urandom_range(0, 3) == 0);
         s.id_br_taken  = ($urandom_range(0, 2) == 0);
         s.ex_memread   = 1'($urandom);
         s.ex_regwrite  = ($urandom_range(0, 3) != 0);
         s.ex_flagwrite = 1'($urandom);
         s.mem_req      = ($urandom_range(0, 2) == 0);
         s.mem_ready    = ($urandom_range(0, 3) == 0);
         applyStimulus(s);
      end

      driveDone = 1'b1;
   end

   // Wrap-up with a hard time bound so the run always ends.
   initial begin
      fork
         begin
            wait (driveDone);
            repeat (3) @(negedge clk);
         end
         begin
            #200000;
            $display("[TB] FAIL timeout stimulus did not complete");
            miscompares++;
         end
      join_any
      if (expQ.size() != 0) begin
         $display("[TB] FAIL pending got=%0d expected=0 unchecked entries", expQ.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
